// File: rtl/sad_acc.sv
// Sum-of-absolute-differences accumulator: folds LEN operand pairs into one result with a valid/ready handshake.
// Optional macro SAD_SAT_EN: clamp the accumulator on carry-out instead of wrapping.
module sad_acc #(
    parameter int WIDTH = 4,
    parameter int LEN   = 4,
    parameter int ACC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   sad,
    output logic               ovf
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] diff;
    logic [ACC_W:0]   sum;
    logic             accept;

    assign accept = in_valid && in_ready;
    assign diff   = (a >= b) ? (a - b) : (b - a);
    // One extra bit catches the carry-out that drives ovf.
    assign sum    = {1'b0, acc_q} + (ACC_W+1)'(diff);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clr) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
`ifdef SAD_SAT_EN
                        if (sum[ACC_W] || ovf_q) acc_d = '1;
                        else                     acc_d = sum[ACC_W-1:0];
`else
                        acc_d = sum[ACC_W-1:0];
`endif
                        if (sum[ACC_W]) ovf_d = 1'b1;
                        if (cnt_q == LAST) begin
                            state_d = DONE;
                            cnt_d   = '0;
                        end else begin
                            state_d = ACCUM;
                            cnt_d   = cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // The accumulator doubles as the result register; it is frozen while in DONE.
    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign sad       = acc_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_sad_acc.sv
// Bench for sad_acc: default, ACC_W=5 and LEN=1 instances share stimulus; sel picks the one being checked.
module tb_sad_acc;

    logic clk = 1'b0;
    logic rst_n, clr, in_valid, out_ready;
    logic [3:0] a, b;
    always #5 clk = ~clk;

    logic       ir0, ov0, of0, ir1, ov1, of1, ir2, ov2, of2;
    logic [7:0] sad0, sad2;
    logic [4:0] sad1;

    sad_acc u0 (.clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir0),
                .a(a), .b(b), .out_valid(ov0), .out_ready(out_ready), .sad(sad0), .ovf(of0));
    sad_acc #(.ACC_W(5)) u1 (.clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir1),
                .a(a), .b(b), .out_valid(ov1), .out_ready(out_ready), .sad(sad1), .ovf(of1));
    sad_acc #(.LEN(1)) u2 (.clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir2),
                .a(a), .b(b), .out_valid(ov2), .out_ready(out_ready), .sad(sad2), .ovf(of2));

    int sel = 0;
    logic       m_ir, m_ov, m_ovf;
    logic [7:0] m_sad;
    always_comb begin
        m_ir = ir0; m_ov = ov0; m_ovf = of0; m_sad = sad0;
        case (sel)
            1: begin m_ir = ir1; m_ov = ov1; m_ovf = of1; m_sad = {3'b000, sad1}; end
            2: begin m_ir = ir2; m_ov = ov2; m_ovf = of2; m_sad = sad2; end
            default: ;
        endcase
    end

    typedef struct { logic [7:0] sad; logic ovf; } res_t;
    res_t q[$];

    typedef struct { logic v; logic [3:0] a; logic [3:0] b; logic [7:0] sad; logic ov; } vec_t;
    vec_t tbl[7];

    int tests = 0;
    int fails = 0;
    bit done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [3:0] ia, input logic [3:0] ib,
                       input logic ordy, input logic iclr);
        in_valid = v; a = ia; b = ib; out_ready = ordy; clr = iclr;
        @(posedge clk);
        #1;
    endtask

    function automatic res_t mk(input logic [7:0] s, input logic o);
        res_t r;
        r.sad = s; r.ovf = o;
        return r;
    endfunction

    // Scoreboard: a handshake seen mid-cycle completes on the coming edge.
    initial begin
        res_t e;
        while (!done) begin
            @(negedge clk);
            if (rst_n && m_ov && out_ready && !clr) begin
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_result: got sad=%0d expected none", m_sad);
                end else begin
                    e = q.pop_front();
                    chk("sb_sad", m_sad, e.sad);
                    chk("sb_ovf", m_ovf, e.ovf);
                end
            end
        end
    end

    initial begin
        tbl[0] = '{1'b1, 4'd3,  4'd12, 8'd9,  1'b0};
        tbl[1] = '{1'b0, 4'd7,  4'd0,  8'd9,  1'b0};
        tbl[2] = '{1'b1, 4'd10, 4'd4,  8'd15, 1'b0};
        tbl[3] = '{1'b0, 4'd1,  4'd9,  8'd15, 1'b0};
        tbl[4] = '{1'b0, 4'd0,  4'd0,  8'd15, 1'b0};
        tbl[5] = '{1'b1, 4'd5,  4'd5,  8'd15, 1'b0};
        tbl[6] = '{1'b1, 4'd12, 4'd0,  8'd27, 1'b1};

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sad0", sad0, 0); chk("rst_ov0", ov0, 0); chk("rst_ovf0", of0, 0);
        chk("rst_sad1", sad1, 0); chk("rst_ov2", ov2, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ir0", ir0, 1); chk("rst_ir2", ir2, 1);

        // Back-to-back block
        sel = 0;
        q.push_back(mk(8'd27, 1'b0));
        cyc(1, 3, 12, 0, 0);
        cyc(1, 10, 4, 0, 0);
        cyc(1, 5, 5, 0, 0);
        chk("b2b_not_done", m_ov, 0);
        cyc(1, 12, 0, 0, 0);
        chk("b2b_ov", m_ov, 1); chk("b2b_sad", m_sad, 27); chk("b2b_ovf", m_ovf, 0);

        // Backpressure: result held, nothing accepted
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 2, 0, 0);
            chk("hold_sad", m_sad, 27); chk("hold_ir", m_ir, 0); chk("hold_ov", m_ov, 1);
        end
        cyc(1, 1, 2, 1, 0);
        chk("drain_ov", m_ov, 0); chk("drain_sad", m_sad, 0); chk("drain_ir", m_ir, 1);
        q.push_back(mk(8'd4, 1'b0));
        for (int i = 0; i < 4; i++) cyc(1, 1, 2, 0, 0);
        chk("blk2_ov", m_ov, 1); chk("blk2_sad", m_sad, 4);
        cyc(0, 0, 0, 1, 0);
        chk("blk2_drained", m_ov, 0);

        // Bubbles between pairs, table-driven
        q.push_back(mk(8'd27, 1'b0));
        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].v, tbl[i].a, tbl[i].b, 0, 0);
            chk($sformatf("bub%0d_sad", i), m_sad, tbl[i].sad);
            chk($sformatf("bub%0d_ov", i), m_ov, tbl[i].ov);
        end
        cyc(0, 0, 0, 1, 0);

        // Overflow with ACC_W=5
        sel = 1;
        cyc(0, 0, 0, 0, 1);
`ifdef SAD_SAT_EN
        q.push_back(mk(8'd31, 1'b1));
`else
        q.push_back(mk(8'd28, 1'b1));
`endif
        cyc(1, 15, 0, 0, 0);
        cyc(1, 15, 0, 0, 0);
        chk("ovf_before_carry", m_ovf, 0);
        cyc(1, 15, 0, 0, 0);
        chk("ovf_set", m_ovf, 1);
        cyc(1, 15, 0, 0, 0);
        chk("ovf_sticky", m_ovf, 1); chk("ovf_ov", m_ov, 1);
        cyc(0, 0, 0, 1, 0);
        chk("ovf_cleared", m_ovf, 0);

        // clr with a simultaneous valid pair
        sel = 0;
        cyc(0, 0, 0, 0, 1);
        cyc(1, 3, 1, 0, 0);
        cyc(1, 3, 1, 0, 0);
        chk("clr_pre_sad", m_sad, 4);
        cyc(1, 9, 0, 0, 1);
        chk("clr_sad", m_sad, 0); chk("clr_ov", m_ov, 0); chk("clr_ir", m_ir, 1);
        q.push_back(mk(8'd8, 1'b0));
        for (int i = 0; i < 4; i++) cyc(1, 2, 0, 0, 0);
        chk("clr_newblk_ov", m_ov, 1);
        cyc(0, 0, 0, 1, 0);

        // Reset mid-block
        cyc(1, 6, 0, 0, 0);
        cyc(1, 6, 0, 0, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstmid_sad", m_sad, 0); chk("rstmid_ov", m_ov, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.push_back(mk(8'd4, 1'b0));
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0);
        chk("rstmid_not_done", m_ov, 0);
        cyc(1, 0, 1, 0, 0);
        chk("rstmid_ov", m_ov, 1);
        cyc(0, 0, 0, 1, 0);

        // LEN=1: every accept finishes a block
        sel = 2;
        cyc(0, 0, 0, 0, 1);
        q.push_back(mk(8'd5, 1'b0));
        q.push_back(mk(8'd9, 1'b0));
        cyc(1, 7, 2, 1, 0);
        chk("len1_ov_a", m_ov, 1); chk("len1_sad_a", m_sad, 5);
        cyc(1, 0, 9, 1, 0);
        chk("len1_gap", m_ov, 0);
        begin
            int n = 0;
            while (!m_ov && n < 10) begin
                cyc(1, 0, 9, 1, 0);
                n++;
            end
            chk("len1_ov_b", m_ov, 1);
        end
        chk("len1_sad_b", m_sad, 9);
        cyc(0, 0, 0, 1, 0);
        chk("len1_end", m_ov, 0);

        chk("sb_empty", q.size(), 0);
        done = 1;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
